// File: rtl/rom_lookup.sv
// rom_lookup: registered CORDIC angle/shift table, Q2.30, one lookup per cycle.
module rom_lookup (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  index,
  input  logic [1:0]  mode,
  output logic [31:0] module_output
);
  logic [31:0] pow_d, lin_d, circ_d, hyp_d, out_d, out_q;
  always_comb begin
    pow_d  = 32'h4000_0000 >> index;
    lin_d  = (index == 5'd31) ? 32'd1 : pow_d;
    circ_d = pow_d;
    hyp_d  = (index == 5'd31) ? 32'd1 : pow_d;
    // From i = 10 up, atan/atanh differ from 2^-i by under half an LSB, so the shift covers them
    case (index)
      5'd0: begin circ_d = 32'h3243_F6A9; hyp_d = 32'h0000_0000; end
      5'd1: begin circ_d = 32'h1DAC_6705; hyp_d = 32'h2327_D4F5; end
      5'd2: begin circ_d = 32'h0FAD_BAFD; hyp_d = 32'h1058_AEFB; end
      5'd3: begin circ_d = 32'h07F5_6EA7; hyp_d = 32'h080A_C48E; end
      5'd4: begin circ_d = 32'h03FE_AB77; hyp_d = 32'h0401_5623; end
      5'd5: begin circ_d = 32'h01FF_D55C; hyp_d = 32'h0200_2AB1; end
      5'd6: begin circ_d = 32'h00FF_FAAB; hyp_d = 32'h0100_0556; end
      5'd7: begin circ_d = 32'h007F_FF55; hyp_d = 32'h0080_00AB; end
      5'd8: begin circ_d = 32'h003F_FFEB; hyp_d = 32'h0040_0015; end
      5'd9: begin circ_d = 32'h001F_FFFD; hyp_d = 32'h0020_0003; end
      default: ;
    endcase
    out_d = (mode == 2'b00) ? circ_d :
            (mode == 2'b01) ? lin_d  :
            (mode == 2'b10) ? hyp_d  : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_q <= 32'd0;
    else        out_q <= out_d;
  assign module_output = out_q;
endmodule

// File: tb/tb_rom_lookup.sv
// tb_rom_lookup: directed checks of the CORDIC lookup ROM against hand-computed Q2.30 values.
module tb_rom_lookup;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  index = 5'd5;
  logic [1:0]  mode = 2'b01;
  logic [31:0] module_output;
  logic [31:0] hyp_exp [32];
  logic [31:0] held;
  int checks = 0;
  int errors = 0;

  rom_lookup dut (
    .clk(clk), .rst_n(rst_n), .index(index), .mode(mode), .module_output(module_output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (!$isunknown(obs) && ((obs >= exp ? obs - exp : exp - obs) <= 32'd1)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h+-1", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] m, input logic [4:0] i);
    mode = m;
    index = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    hyp_exp[0]  = 32'h0000_0000; hyp_exp[1]  = 32'h2327_D4F5;
    hyp_exp[2]  = 32'h1058_AEFB; hyp_exp[3]  = 32'h080A_C48E;
    hyp_exp[4]  = 32'h0401_5623; hyp_exp[5]  = 32'h0200_2AB1;
    hyp_exp[6]  = 32'h0100_0556; hyp_exp[7]  = 32'h0080_00AB;
    hyp_exp[8]  = 32'h0040_0015; hyp_exp[9]  = 32'h0020_0003;
    for (int i = 10; i < 31; i++) hyp_exp[i] = 32'd1 << (30 - i);
    hyp_exp[31] = 32'd1;

    #1 chk("reset_before_clk", module_output, 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("reset_held", module_output, 32'h0);
    rst_n = 1'b1;
    chk("release_no_edge", module_output, 32'h0);
    @(posedge clk); #1;
    chk("release_lin5", module_output, 32'h0200_0000);

    for (int i = 0; i < 32; i++) begin
      step(2'b10, 5'(i));
      if (i < 2) chk($sformatf("hyp_%0d", i), module_output, hyp_exp[i]);
      else       chk_tol($sformatf("hyp_%0d", i), module_output, hyp_exp[i]);
    end

    step(2'b00, 5'd0);  chk("circ_0", module_output, 32'h3243_F6A9);
    step(2'b00, 5'd1);  chk("circ_1", module_output, 32'h1DAC_6705);
    step(2'b00, 5'd2);  chk_tol("circ_2", module_output, 32'h0FAD_BAFD);
    step(2'b00, 5'd10); chk_tol("circ_10", module_output, 32'h0010_0000);
    step(2'b00, 5'd31); chk("circ_31", module_output, 32'h0);

    held = module_output;
    step(2'b01, 5'd0);
    held = module_output;
    index = 5'd9; mode = 2'b00;
    #2 chk("hold_mid_cycle", module_output, held);
    chk("lin_0", held, 32'h4000_0000);

    for (int i = 1; i < 32; i++) begin
      step(2'b01, 5'(i));
      chk($sformatf("lin_%0d", i), module_output, (i == 31) ? 32'd1 : (32'h4000_0000 >> i));
      if (i == 15) begin
        rst_n = 1'b0;
        #1 chk("async_reset", module_output, 32'h0);
        @(posedge clk); #1;
        chk("reset_over_edge", module_output, 32'h0);
        rst_n = 1'b1;
      end
    end

    step(2'b11, 5'd0);  chk("rsv_0", module_output, 32'h0);
    step(2'b11, 5'd7);  chk("rsv_7", module_output, 32'h0);
    step(2'b11, 5'd31); chk("rsv_31", module_output, 32'h0);

    step(2'b00, 5'd3); chk("sw_circ3", module_output, 32'h07F5_6EA7);
    step(2'b10, 5'd3); chk("sw_hyp3", module_output, 32'h080A_C48E);
    step(2'b00, 5'd3); chk("sw_circ3b", module_output, 32'h07F5_6EA7);
    step(2'b10, 5'd1); chk("sw_hyp1", module_output, 32'h2327_D4F5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_lookup.md
ROM_LOOKUP -- requirements
Module: rom_lookup

Interface
REQ-001 Parameters: none; the table width is fixed at 32 bits and the depth at 32 entries per mode.
REQ-002 clk  input  1  Single clock for the block; all registers update on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 index  input  5  CORDIC iteration number i, range 0..31.
REQ-005 mode  input  2  Table select: 2'b00 CIRCULAR, 2'b01 LINEAR, 2'b10 HYPERBOLIC, 2'b11 reserved; encodings match the CIRCULAR/LINEAR/HYPERBOLIC macros in CONSTANTS.v.
REQ-006 module_output  output  32  Registered table value for (mode, index).

Function
REQ-007 Number format SHALL be unsigned fixed point Q2.30, value = round(x * 2^30), with ties rounded away from zero.
REQ-008 CIRCULAR: the entry for index i SHALL be atan(2^-i) in radians, for i = 0..31.
REQ-009 LINEAR: the entry for index i SHALL be 2^-i; index 0 = 0x40000000, index 30 = 0x00000001, index 31 = 0x00000001 (tie rounds up).
REQ-010 HYPERBOLIC: the entry for index i SHALL be atanh(2^-i) for i = 1..31.
REQ-011 HYPERBOLIC index 0 (atanh(1), undefined) SHALL output 0x00000000.
REQ-012 Reserved mode 2'b11 SHALL output 0x00000000 for every index.
REQ-013 Table contents SHALL be constants fixed at synthesis (ROM), with no write port.
REQ-014 Latency: module_output SHALL reflect the index/mode sampled at a rising clk edge, valid right after that edge (1-cycle latency).
REQ-015 Throughput: one lookup per cycle; a new index/mode may be applied every cycle.
REQ-016 The output SHALL hold its value between edges even if the inputs change mid-cycle.
REQ-017 The table SHALL contain no X or uninitialised entries; all 96 defined entries plus the zero cases are fully specified.
REQ-018 Index wrap: only indices 0..31 exist; no out-of-range handling is needed beyond the 5-bit width.
REQ-019 Reference entries:
- CIRCULAR[0] = 0x3243F6A9 (pi/4)
- CIRCULAR[1] = 0x1DAC6705
- HYPERBOLIC[1] = 0x2327D4F5 (atanh 0.5)
- LINEAR[1] = 0x20000000
REQ-020 Monotonicity: within each mode, entries for i >= 1 SHALL be non-increasing as i increases.

Reset
REQ-021 While rst_n = 0, module_output SHALL be 0x00000000, asynchronously and regardless of clk.
REQ-022 Deasserting rst_n SHALL take effect on the next rising clk edge.
REQ-023 At that edge the output SHALL load the entry for the current index/mode.
REQ-024 Asserting rst_n in the middle of a lookup sequence SHALL force the output to 0 immediately.
REQ-025 After reset is released, lookups SHALL resume without any extra wait cycles.

Verification
REQ-026 Reset: hold rst_n = 0 with index = 5, mode = LINEAR and toggle clk -> module_output = 0x00000000; release rst_n, then one edge -> 0x02000000.
REQ-027 HYPERBOLIC sweep: mode = 2'b10, apply index 0..31 one per cycle -> outputs 0x00000000, then 0x2327D4F5, ..., each matching round(atanh(2^-i) * 2^30) within ±1 LSB, one cycle after the index is applied.
REQ-028 CIRCULAR spot checks:
- index 0 -> 0x3243F6A9
- index 1 -> 0x1DAC6705
- index 31 -> 0x00000000
REQ-029 LINEAR sweep: index i -> 0x40000000 >> i for i = 0..30; index 31 -> 0x00000001.
REQ-030 Reserved mode and mid-sequence reset:
- mode = 2'b11, any index -> 0x00000000
- switch mode between CIRCULAR and HYPERBOLIC on consecutive cycles at index 3 -> each output matches the mode registered on the preceding edge
- pulse rst_n low mid-sweep -> output is 0 at once, then correct one edge after release
